// File: rtl/rr_index_arbiter_pkg.sv
// Shared constants and FSM state type for the 8-way round-robin index arbiter.
package rr_index_arbiter_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping.
module rr_pick
  import rr_index_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] masked;

  // Upper copy of req covers the wrapped positions; lowest surviving bit wins.
  always_comb begin
    dbl    = {req, req};
    masked = dbl & ({(2*N_REQ){1'b1}} << ptr);
    found  = 1'b0;
    idx    = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (masked[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter over 8 requesters; registered grant index under valid/ready.
module rr_index_arbiter
  import rr_index_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy
);
  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [N_REQ-1:0] pick_req;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  // While granting, search assumes the current grant is accepted: rotated ptr, own bit masked.
  always_comb begin
    pick_req = req;
    pick_ptr = ptr;
    if (state == GRANT) begin
      pick_req = req & ~(N_REQ'(1) << grant_idx);
      pick_ptr = grant_idx + IDX_W'(1);
    end
  end

  rr_pick u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state       <= GRANT;
            grant_valid <= 1'b1;
            grant_idx   <= pick_idx;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            ptr <= pick_ptr;
            if (pick_found) begin
              grant_idx <= pick_idx;
            end else begin
              state       <= IDLE;
              grant_valid <= 1'b0;
            end
          end else if (!req[grant_idx]) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = grant_valid;
endmodule
